// File: rtl/scc_mem_pkg.sv
// Shared types and helpers for the SCC data memory controller.
package scc_mem_pkg;

  localparam int unsigned DM_LAT_W = 4;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT,
    RESP
  } dm_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response handshake between the MEM stage and the data memory controller.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_storage_array.sv
// Byte-strobed register array: one write port, one combinational read port.
// Optional per-byte even parity when DM_PARITY_EN is defined.
module dm_storage_array
  import scc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [clog2(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic [clog2(DEPTH)-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          par_err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

`ifdef DM_PARITY_EN
  logic [NumBytes-1:0] par_q [DEPTH];

  // Parity bit is the XOR of its byte, so byte plus bit always has even weight.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wstrb[b]) par_q[waddr][b] <= ^wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NumBytes; b++) begin
      par_err = par_err | ((^rdata[8*b +: 8]) != par_q[raddr][b]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory behind a valid/ready handshake with clear sequence,
// programmable read latency and address error reporting. Parity: DM_PARITY_EN.
module data_memory_ctrl
  import scc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus,
  output logic               init_done
);

  localparam int unsigned NumBytes  = DATA_WIDTH / 8;
  localparam int unsigned Lsb       = clog2(NumBytes);
  localparam int unsigned Aw        = clog2(DEPTH);
  localparam logic [31:0] AlignMask = (32'd1 << Lsb) - 32'd1;
  localparam logic [Aw:0] ClrLast   = (Aw + 1)'(DEPTH);

  dm_state_t             state_q, state_d;
  logic [Aw:0]           clr_ptr_q, clr_ptr_d;
  logic [DM_LAT_W-1:0]   cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [Aw-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  init_done_q, init_done_d;

  logic                  mem_we;
  logic [Aw-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NumBytes-1:0]   mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_par_err;

  logic                  addr_err;
  logic [Aw-1:0]         req_idx;

  assign addr_err = ((bus.req_addr & AlignMask) != 32'd0) ||
                    ((bus.req_addr >> (Lsb + Aw)) != 32'd0);
  assign req_idx  = bus.req_addr[Lsb +: Aw];

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = bus.req_wdata;
    mem_wstrb   = bus.req_wstrb;

    unique case (state_q)
      CLEAR: begin
        if (clr_ptr_q == ClrLast) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = clr_ptr_q[Aw-1:0];
          mem_wdata = '0;
          mem_wstrb = '1;
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          // Writes commit at the acceptance edge; the response only reports completion.
          mem_we  = bus.req_write && !addr_err;
          write_d = bus.req_write;
          idx_d   = req_idx;
          err_d   = addr_err;
          cnt_d   = DM_LAT_W'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (write_q || err_q) ? '0 : mem_rdata;
          rsp_err_d   = err_q || (!write_q && mem_par_err);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  dm_storage_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .wstrb   (mem_wstrb),
    .raddr   (idx_q),
    .rdata   (mem_rdata),
    .par_err (mem_par_err)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign init_done     = init_done_q;

endmodule
